exins_responder: RTL and testbench

EXINS_RESPONDER -- requirements
Module: exins_responder

---
 rtl/exins_pkg.sv | 27 ++
 rtl/exins_store.sv | 25 ++
 rtl/exins_responder.sv | 122 ++++++++++++
 tb/tb_exins_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exins_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// No logic here: state encoding, response record, fixed instruction words and an address-range helper.
package exins_pkg;

    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
    localparam logic [31:0] ILLEGAL_INSN = 32'h0000_0000;

    // Wide enough for LATENCY up to 7.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } resp_t;

    // True when the byte address lies beyond the end of the instruction store.
    function automatic logic above_store(input logic [31:0] addr, input int unsigned depth_log2);
        return (addr >> (depth_log2 + 32'd2)) != 32'd0;
    endfunction

endpackage

// File: rtl/exins_store.sv
// Instruction store: 2**DEPTH_LOG2 x 32-bit words, one synchronous write port, one combinational read port.
// Read is same-cycle, so a read and write to the same index on one edge return the old word; never stalls.
module exins_store #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    // Deliberately unreset: preloaded program survives a responder reset.
    logic [31:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/exins_responder.sv
// Fetch responder: one outstanding request, response strobe LATENCY cycles after the accepting edge; the core holds exIns_ren (no backpressure).
// Build option EXINS_MISALIGN_TRAP_EN: misaligned fetches return 32'h0 and raise exIns_err with the strobe.
module exins_responder
    import exins_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  exIns_ren,
    input  logic [31:0]           exIns_addr,
    output logic                  exIns_valid,
    output logic [31:0]           exIns_in,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  exIns_err
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
    localparam bit               DIRECT   = (LATENCY == 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    resp_t            r_pend;
    resp_t            w_pend_nxt;
    resp_t            r_out;
    resp_t            w_out_nxt;
    resp_t            w_fetch;
    logic [31:0]      w_store_rdata;
    logic             w_misalign;

    exins_store #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_store (
        .clk     (clk),
        .i_we    (ld_we),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_raddr (exIns_addr[DEPTH_LOG2+1:2]),
        .o_rdata (w_store_rdata)
    );

`ifdef EXINS_MISALIGN_TRAP_EN
    assign w_misalign = |exIns_addr[1:0];
    assign exIns_err  = (r_state == ST_RESP) && r_out.err;
`else
    logic w_unused_ok;
    assign w_misalign  = 1'b0;
    assign w_unused_ok = ^{exIns_addr[1:0], r_out.err};
    assign exIns_err   = 1'b0;
`endif

    // Misalignment outranks the out-of-range substitution.
    always_comb begin
        w_fetch = '{word: w_store_rdata, err: 1'b0};
        if (w_misalign) begin
            w_fetch = '{word: ILLEGAL_INSN, err: 1'b1};
        end else if (above_store(exIns_addr, DEPTH_LOG2)) begin
            w_fetch = '{word: NOP_INSN, err: 1'b0};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_out_nxt   = r_out;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (exIns_ren) begin
                    w_pend_nxt = w_fetch;
                    w_cnt_nxt  = LAT_LOAD;
                    if (DIRECT) begin
                        w_state_nxt = ST_RESP;
                        w_out_nxt   = w_fetch;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Leave WAIT on the edge where the counter reaches zero, so the
                // strobe is sampled exactly LATENCY edges after acceptance.
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RESP;
                    w_out_nxt   = r_pend;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign exIns_valid = (r_state == ST_RESP);
    assign exIns_in    = r_out.word;

endmodule

// File: tb/tb_exins_responder.sv
// Bench for exins_responder: reference model plus directed and randomized fetch/preload traffic.
module tb_exins_responder;

    localparam int DL  = 8;
    localparam int LAT = 2;

    logic          clk     = 1'b0;
    logic          nrst    = 1'b1;
    logic          ren     = 1'b0;
    logic [31:0]   addr    = 32'h0;
    logic          ld_we   = 1'b0;
    logic [DL-1:0] ld_addr = '0;
    logic [31:0]   ld_data = 32'h0;
    logic          valid;
    logic          err;
    logic [31:0]   din;

    exins_responder #(
        .DEPTH_LOG2(DL),
        .LATENCY   (LAT)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .exIns_ren  (ren),
        .exIns_addr (addr),
        .exIns_valid(valid),
        .exIns_in   (din),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .exIns_err  (err)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int n_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: store image, one outstanding request, response due at an absolute edge number.
    logic [31:0] m_mem [256];
    bit          m_busy    = 1'b0;
    longint      edge_n    = 0;
    longint      m_due     = 0;
    logic [31:0] m_word    = 32'h0;
    logic        m_err     = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_word  = 32'h0;

    function automatic void ref_fetch(input logic [31:0] a, output logic [31:0] w, output logic e);
        e = 1'b0;
`ifdef EXINS_MISALIGN_TRAP_EN
        if (a % 4 != 0) begin
            w = 32'h0;
            e = 1'b1;
            return;
        end
`endif
        if (a >= 32'd1024) w = 32'h0000_0013;
        else               w = m_mem[int'(a / 4)];
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy    = 1'b0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_word  = 32'h0;
        end else begin
            edge_n++;
            if (m_busy && edge_n - 1 == m_due) m_busy = 1'b0;
            if (!m_busy && ren) begin
                ref_fetch(addr, m_word, m_err);
                m_busy = 1'b1;
                m_due  = edge_n + LAT - 1;
            end
            if (ld_we) m_mem[ld_addr] = ld_data;
            exp_valid = m_busy && (m_due == edge_n);
            if (exp_valid) begin
                exp_word = m_word;
                exp_err  = m_err;
            end else begin
                exp_err = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", {31'b0, valid}, {31'b0, exp_valid});
        chk("err",   {31'b0, err},   {31'b0, exp_err});
        chk("data",  din,            exp_word);
        if (valid === 1'b1) n_pulses++;
    end

    task automatic ld_word(input logic [DL-1:0] idx, input logic [31:0] d);
        @(posedge clk); #1;
        ld_we = 1'b1; ld_addr = idx; ld_data = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    logic [31:0] b_addr [4];
    logic [31:0] b_word [4];
    logic        b_err  [4];
    int          b_lat  [4];
    bit          b_ld = 1'b0;

    // Issue n fetches with ren held; the next address goes out during each response cycle.
    task automatic burst(input int n);
        @(posedge clk); #1;
        ren  = 1'b1;
        addr = b_addr[0];
        if (b_ld) begin
            ld_we = 1'b1; ld_addr = 8'd5; ld_data = 32'hDEAD_BEEF;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ld_we = 1'b0;
            b_lat[i] = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (valid === 1'b1) begin
                    b_lat[i] = c;
                    break;
                end
                @(posedge clk);
            end
            b_word[i] = din;
            b_err[i]  = err;
            if (i + 1 < n) addr = b_addr[i + 1];
            else           ren  = 1'b0;
        end
        b_ld = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        #2 nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_data",  din,            32'h0);
        chk("rst_err",   {31'b0, err},   32'h0);
        @(posedge clk); #2 nrst = 1'b1;

        @(posedge clk); #1;
        ld_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_addr = 8'(i);
            ld_data = $urandom;
            @(posedge clk); #1;
        end
        ld_we = 1'b0;

        ld_word(8'h3F, 32'h0050_0093);
        ld_word(8'h00, 32'hA000_0001);
        ld_word(8'h01, 32'hA000_0002);
        ld_word(8'h02, 32'hA000_0003);
        ld_word(8'h40, 32'h4040_4040);
        ld_word(8'h05, 32'h1111_1111);

        b_addr[0] = 32'hFC;
        burst(1);
        chk("lat_fc",  32'(b_lat[0]), 32'd2);
        chk("word_fc", b_word[0],     32'h0050_0093);

        p0 = n_pulses;
        b_addr[0] = 32'h0; b_addr[1] = 32'h4; b_addr[2] = 32'h8;
        burst(3);
        chk("pulses_b3", 32'(n_pulses - p0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("lat_b3", 32'(b_lat[i]), 32'd2);
        end
        chk("word_b3_0", b_word[0], 32'hA000_0001);
        chk("word_b3_1", b_word[1], 32'hA000_0002);
        chk("word_b3_2", b_word[2], 32'hA000_0003);

        b_addr[0] = 32'h0000_1000;
        burst(1);
        chk("word_oor", b_word[0],           32'h0000_0013);
        chk("err_oor",  {31'b0, b_err[0]},   32'h0);

        b_addr[0] = 32'h102;
        burst(1);
`ifdef EXINS_MISALIGN_TRAP_EN
        chk("word_mis", b_word[0],         32'h0);
        chk("err_mis",  {31'b0, b_err[0]}, 32'h1);
`else
        chk("word_mis", b_word[0],         32'h4040_4040);
        chk("err_mis",  {31'b0, b_err[0]}, 32'h0);
`endif

        b_addr[0] = 32'h14;
        b_ld = 1'b1;
        burst(1);
        chk("word_rbw_old", b_word[0], 32'h1111_1111);
        burst(1);
        chk("word_rbw_new", b_word[0], 32'hDEAD_BEEF);

        // Reset while a request sits in WAIT.
        p0 = n_pulses;
        @(posedge clk); #1;
        ren = 1'b1; addr = 32'hFC;
        @(posedge clk); #2;
        nrst = 1'b0; ren = 1'b0;
        repeat (4) @(posedge clk);
        #2 nrst = 1'b1;
        repeat (8) @(posedge clk);
        chk("pulses_rst", 32'(n_pulses - p0), 32'd0);
        b_addr[0] = 32'hFC;
        burst(1);
        chk("word_keep", b_word[0], 32'h0050_0093);

        repeat (2000) begin
            @(posedge clk); #1;
            ren = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       addr = $urandom;
                1:       addr = 32'($urandom_range(0, 1023));
                default: addr = 32'($urandom_range(0, 255)) * 32'd4;
            endcase
            ld_we   = ($urandom_range(0, 3) == 0);
            ld_addr = 8'($urandom);
            ld_data = $urandom;
        end
        @(posedge clk); #1;
        ren = 1'b0; ld_we = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
